ram_arbiter: RTL and testbench
==============================

# ram_arbiter

- Shares the single-port 32-bit program/data RAM between two requesters: the CPU memory path (driven from control_unit / MDR-MAR sequencing) and an external program loader/debug port.
- Accepts one request at a time, drives the RAM for exactly one access cycle, waits out the RAM read latency, and returns a one-cycle done pulse with read data to the winner.
- Sits between minisrc and the memory array.
- Exposes `busy` so the control unit can stall fetch/load/store sequencing.

## Interface

Parameters:
- `ADDR_W`, 9: RAM word-address width (512 words).
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: RAM read latency in cycles, legal range 1–4.

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  reset, asynchronous and active-low.
- `cpu_req`  in  1  CPU access request; held high until `cpu_done`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  last CPU read data.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`  in  1/1/ADDR_W/DATA_W  loader request set; same rules as the CPU set.
- `ld_done`  out  1  loader completion pulse.
- `ld_rdata`  out  DATA_W  last loader read data.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable; only high together with `ram_en`.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data; valid `RD_LAT` cycles after the `ram_en` read cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation

FSM states: IDLE, ACCESS, WAIT, DONE.

- **IDLE:** if any request is high at the rising edge, latch winner, `we`, `addr` and `wdata` into internal registers, then go to ACCESS. Otherwise stay in IDLE.
- **ACCESS:** `ram_en` = 1 for exactly one cycle, with `ram_we`, `ram_addr` and `ram_wdata` taken from the latched registers.
  - Write: go to DONE.
  - Read: go to WAIT and load the latency counter with `RD_LAT`.
- **WAIT:** decrement the counter each cycle. On the cycle where the counter reads 1, capture `ram_rdata` into the winner's rdata register, then go to DONE.
- **DONE:** assert the winner's done output for one cycle, update `last_grant`, then go to IDLE.

Arbitration (in IDLE, both requests high): see Configuration.

Data and request rules:
- `ram_addr` and `ram_wdata` hold their last latched values outside ACCESS.
- `ram_en` and `ram_we` are 0 outside ACCESS.
- `cpu_rdata` and `ld_rdata` change only on a completed read by that requester; writes leave them unchanged.
- The requester must drop req in the cycle after done. If req is still high in the following IDLE cycle, it is a new request.
- A req change by the non-granted requester during ACCESS, WAIT or DONE has no effect until IDLE.
- A change of `we`, `addr` or `wdata` after latching has no effect on the current access.

Reset (`Reset` = 0, asynchronous), including mid-operation:
- State goes to IDLE.
- All outputs go to 0: `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, both done, both rdata, `busy`.
- `last_grant` is set to loader.
- An in-flight access is aborted with no done pulse.

## Timing

Request sampled at edge 0 (IDLE):
- ACCESS is cycle 1.
- Write: done in cycle 2; write latency 2 cycles.
- Read: WAIT occupies cycles 2 .. 1+`RD_LAT`; done in cycle 2+`RD_LAT`. With `RD_LAT` = 1, done is in cycle 3.
- rdata is valid in the done cycle and holds afterwards.

Throughput:
- Minimum spacing between ACCESS cycles is 3 (write) or 3+`RD_LAT` (read), because of the mandatory IDLE cycle.
- Back-to-back requests from one requester each pay the IDLE cycle.
- `busy` rises in cycle 1 and falls in the cycle after DONE.

## Configuration

Macro: `RAM_ARB_ROUNDROBIN_EN`.
- **Defined:** round-robin on a tie; the requester that did not win the previous completed access wins. After reset the CPU wins the first tie.
- **Undefined:** fixed priority; the CPU always wins a tie, and the loader is served only when `cpu_req` is low in IDLE. `last_grant` is still maintained but unused.

## Test plan

- **Reset:**
  - Apply `Reset` = 0 mid-WAIT of a CPU read: all outputs 0 immediately, no `cpu_done`.
  - Release, then issue a CPU write: `ram_en` high in cycle 1.
- **CPU write then read (`RD_LAT` = 1):**
  - Write 0xDEADBEEF to 0x00A: `ram_we` = 1 in cycle 1, `cpu_done` in cycle 2.
  - Read 0x00A: `cpu_done` in cycle 3, `cpu_rdata` = 0xDEADBEEF.
- **Loader read:**
  - Loader reads 0x1FF, returning 0x12345678: `ld_rdata` = 0x12345678.
  - `cpu_rdata` stays unchanged.
- **Tie, both requests held high for 4 accesses:**
  - With the macro: grant order CPU, LD, CPU, LD.
  - Without: CPU ×4 and `ld_done` never pulses.
- **Latency sweep, `RD_LAT` = 3:** CPU read gives `cpu_done` in cycle 5; `busy` is high cycles 1–5.
- **Held req:** `cpu_req` left high after `cpu_done` starts a second access, with `ram_en` 2 cycles after DONE.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter (rev 1.0): shares one single-port RAM between the CPU and a loader port, one access at a time.
// Build option RAM_ARB_ROUNDROBIN_EN selects round-robin tie-break; default is fixed CPU priority.
`default_nettype none
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int   CNT_W     = 3;
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                owner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                last_grant;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   ld_rdata_q;
  logic                pick_ld;
  logic                any_req;

  assign any_req = cpu_req | ld_req;

`ifdef RAM_ARB_ROUNDROBIN_EN
  // On a tie the loader wins only if the CPU took the previous completed access.
  assign pick_ld = ld_req & (~cpu_req | (last_grant == GRANT_CPU));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pick_ld = ld_req & ~cpu_req;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = we_q ? DONE : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      owner       <= GRANT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      last_grant  <= GRANT_LD;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= pick_ld ? GRANT_LD : GRANT_CPU;
            we_q    <= pick_ld ? ld_we : cpu_we;
            addr_q  <= pick_ld ? ld_addr : cpu_addr;
            wdata_q <= pick_ld ? ld_wdata : cpu_wdata;
          end
        end
        ACCESS: cnt <= CNT_W'(RD_LAT);
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Counter at 1 marks the cycle the RAM presents the read word.
          if (cnt == CNT_W'(1)) begin
            if (owner == GRANT_LD) ld_rdata_q <= ram_rdata;
            else                   cpu_rdata_q <= ram_rdata;
          end
        end
        DONE:    last_grant <= owner;
        default: ;
      endcase
    end
  end

  assign ram_en    = (state == ACCESS);
  assign ram_we    = ram_en & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_done  = (state == DONE) & (owner == GRANT_CPU);
  assign ld_done   = (state == DONE) & (owner == GRANT_LD);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with RD_LAT=1 and RD_LAT=3 instances.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic cpu_req, cpu_we, ld_req, ld_we, cpu_done, ld_done, ram_en, ram_we, busy;
  logic [AW-1:0] cpu_addr, ld_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata, cpu_rdata, ld_rdata, ram_wdata, ram_rdata;

  logic s3_cpu_req, s3_cpu_we, s3_cpu_done, s3_ld_done, s3_ram_en, s3_ram_we, s3_busy;
  logic [AW-1:0] s3_cpu_addr, s3_ram_addr;
  logic [DW-1:0] s3_cpu_wdata, s3_cpu_rdata, s3_ld_rdata, s3_ram_wdata, s3_ram_rdata;
  logic          s3_ld_req, s3_ld_we;
  logic [AW-1:0] s3_ld_addr;
  logic [DW-1:0] s3_ld_wdata;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .Clock(clk), .Reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy));

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .Clock(clk), .Reset(rst_n),
    .cpu_req(s3_cpu_req), .cpu_we(s3_cpu_we), .cpu_addr(s3_cpu_addr), .cpu_wdata(s3_cpu_wdata),
    .cpu_done(s3_cpu_done), .cpu_rdata(s3_cpu_rdata),
    .ld_req(s3_ld_req), .ld_we(s3_ld_we), .ld_addr(s3_ld_addr), .ld_wdata(s3_ld_wdata),
    .ld_done(s3_ld_done), .ld_rdata(s3_ld_rdata),
    .ram_en(s3_ram_en), .ram_we(s3_ram_we), .ram_addr(s3_ram_addr), .ram_wdata(s3_ram_wdata),
    .ram_rdata(s3_ram_rdata), .busy(s3_busy));

  // RAM models: read data appears RD_LAT cycles after the read strobe, junk otherwise.
  logic [DW-1:0] mem1 [0:511];
  logic [DW-1:0] mem3 [0:511];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [0:2];
  always @(posedge clk) begin
    if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
    pipe1 <= (ram_en && !ram_we) ? mem1[ram_addr] : (32'hBAD0_0000 | DW'(cyc));
    if (s3_ram_en && s3_ram_we) mem3[s3_ram_addr] <= s3_ram_wdata;
    pipe3[0] <= (s3_ram_en && !s3_ram_we) ? mem3[s3_ram_addr] : (32'hBAD3_0000 | DW'(cyc));
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_rdata    = pipe1;
  assign s3_ram_rdata = pipe3[2];

  typedef struct {
    bit          who;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];
  int vectors = 0;
  int errors  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void timeout(string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out waiting for done (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin : mon1
    exp_t e;
    if (cpu_done || ld_done) begin
      check("done_onehot", {cpu_done, ld_done}, (ld_done ? 2'b01 : 2'b10));
      if (q1.size() == 0) begin
        check("unexpected_done", {cpu_done, ld_done}, 2'b00);
      end else begin
        e = q1.pop_front();
        check("done_who", ld_done, e.who);
        check("done_cycle", cyc, e.cyc);
        if (e.rd) check(e.who ? "ld_rdata" : "cpu_rdata", e.who ? ld_rdata : cpu_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (s3_cpu_done || s3_ld_done) begin
      if (q3.size() == 0) begin
        check("lat3_unexpected_done", {s3_cpu_done, s3_ld_done}, 2'b00);
      end else begin
        e = q3.pop_front();
        check("lat3_done_who", s3_ld_done, e.who);
        check("lat3_done_cycle", cyc, e.cyc);
        if (e.rd) check("lat3_cpu_rdata", s3_cpu_rdata, e.data);
      end
    end
  end

  // Called in an IDLE cycle just after a negedge; returns in the IDLE cycle after DONE.
  task automatic access1(bit who, bit we, logic [8:0] a, logic [31:0] d, logic [31:0] rd_exp);
    exp_t e;
    int   n;
    if (who) begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = d; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    e.who = who; e.rd = !we; e.data = rd_exp; e.cyc = cyc + (we ? 2 : 3);
    q1.push_back(e);
    @(negedge clk);
    check("access_en", ram_en, 1);
    check("access_we", ram_we, we);
    check("access_addr", ram_addr, a);
    if (we) check("access_wdata", ram_wdata, d);
    n = 0;
    while (!(cpu_done || ld_done) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("access1");
    cpu_req = 0; ld_req = 0;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n, cnt, c0;
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    s3_cpu_req = 0; s3_cpu_we = 0; s3_cpu_addr = '0; s3_cpu_wdata = '0;
    s3_ld_req = 0; s3_ld_we = 0; s3_ld_addr = '0; s3_ld_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    rst_n = 1;
    @(negedge clk);

    access1(0, 1, 9'h00A, 32'hDEADBEEF, '0);
    access1(0, 0, 9'h00A, '0, 32'hDEADBEEF);
    access1(1, 1, 9'h1FF, 32'h12345678, '0);
    access1(1, 0, 9'h1FF, '0, 32'h12345678);
    check("cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    check("ld_rdata_held", ld_rdata, 32'h12345678);

    // Tie: both held high for four accesses; the loader completed last.
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'h11111111;
    ld_req  = 1; ld_we  = 1; ld_addr  = 9'h020; ld_wdata  = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      e.rd = 0; e.data = '0; e.cyc = cyc + 2 + 3 * k;
`ifdef RAM_ARB_ROUNDROBIN_EN
      e.who = (k % 2 == 1);
`else
      e.who = 0;
`endif
      q1.push_back(e);
    end
    cnt = 0; n = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clk); n++;
      if (cpu_done || ld_done) cnt++;
    end
    if (cnt < 4) timeout("tie");
    cpu_req = 0; ld_req = 0;
    @(negedge clk);

    // Held request: second access starts two cycles after DONE.
    c0 = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h00A;
    e.who = 0; e.rd = 1; e.data = 32'hDEADBEEF; e.cyc = c0 + 3; q1.push_back(e);
    e.cyc = c0 + 7; q1.push_back(e);
    repeat (4) @(negedge clk);
    check("held_idle_en", ram_en, 0);
    check("held_idle_busy", busy, 0);
    @(negedge clk);
    check("held_reaccess_en", ram_en, 1);
    cpu_req = 0;
    repeat (3) @(negedge clk);

    // RD_LAT = 3 instance: write, then read with busy profile.
    s3_cpu_req = 1; s3_cpu_we = 1; s3_cpu_addr = 9'h005; s3_cpu_wdata = 32'hCAFEF00D;
    e.who = 0; e.rd = 0; e.data = '0; e.cyc = cyc + 2; q3.push_back(e);
    n = 0;
    while (!s3_cpu_done && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("lat3_write");
    s3_cpu_req = 0;
    @(negedge clk);
    check("lat3_idle_busy", s3_busy, 0);
    s3_cpu_req = 1; s3_cpu_we = 0;
    e.rd = 1; e.data = 32'hCAFEF00D; e.cyc = cyc + 5; q3.push_back(e);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) s3_cpu_req = 0;
      check("lat3_busy", s3_busy, (k <= 5));
    end

    // Reset in the WAIT cycle of a CPU read: everything clears, no done.
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h00A;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 0; cpu_req = 0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ram_en", ram_en, 0);
    check("rst_mid_ram_we", ram_we, 0);
    check("rst_mid_ram_addr", ram_addr, 0);
    check("rst_mid_ram_wdata", ram_wdata, 0);
    check("rst_mid_cpu_done", cpu_done, 0);
    check("rst_mid_ld_done", ld_done, 0);
    check("rst_mid_cpu_rdata", cpu_rdata, 0);
    check("rst_mid_ld_rdata", ld_rdata, 0);
    check("rst_mid_lat3_rdata", s3_cpu_rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    access1(0, 1, 9'h003, 32'h0BADF00D, '0);
    repeat (3) @(negedge clk);

    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
